// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encoding, data/strobe widths and the latency counter width.
package dmem_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = 4;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Read responses carry storage data; write responses always carry zero.
  function automatic logic [DataW-1:0] rsp_word(input logic is_write,
                                                input logic [DataW-1:0] word);
    return is_write ? '0 : word;
  endfunction

endpackage

// File: rtl/m_dmem_array.sv
// Word-addressed storage: one synchronous byte-enabled write port, one asynchronous read port.
// Contents are never cleared by reset.
module m_dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [StrbW-1:0] be_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < StrbW; i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/m_dmem_resp.sv
// Fixed-latency data-memory responder: IDLE -> WAIT -> RESP handshake FSM around m_dmem_array.
// Optional DMEM_BYTE_STROBE_EN honours w_req_strb; otherwise every write updates the full word.
module m_dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 12
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_req_valid,
  output logic             w_req_ready,
  input  logic             w_req_we,
  input  logic [AW-1:0]    w_req_addr,
  input  logic [DataW-1:0] w_req_wdata,
  input  logic [StrbW-1:0] w_req_strb,
  output logic             w_rsp_valid,
  input  logic             w_rsp_ready,
  output logic [DataW-1:0] w_rsp_rdata
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("m_dmem_resp: LATENCY must be in 1..15");
  end

  localparam logic [CntW-1:0] LatLoad = CntW'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] rdata_q, rdata_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;

  logic             accept;
  logic             mem_we;
  logic [StrbW-1:0] mem_be;
  logic [AW-1:0]    rd_addr;
  logic [DataW-1:0] rd_word;

  // Reset wins over acceptance, so a request on a reset edge never writes.
  assign accept = (state_q == StIdle) && w_req_valid && !w_rst;
  assign mem_we = accept && w_req_we;

`ifdef DMEM_BYTE_STROBE_EN
  assign mem_be = w_req_strb;
`else
  // Strobes are ignored: the OR with all-ones forces full-word writes.
  assign mem_be = w_req_strb | {StrbW{1'b1}};
`endif

  m_dmem_array #(
    .AW(AW)
  ) u_array (
    .clk_i   (w_clk),
    .we_i    (mem_we),
    .waddr_i (w_req_addr),
    .wdata_i (w_req_wdata),
    .be_i    (mem_be),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    we_d    = we_q;
    rd_addr = addr_q;
    unique case (state_q)
      StIdle: begin
        if (w_req_valid) begin
          addr_d = w_req_addr;
          we_d   = w_req_we;
          if (LATENCY == 1) begin
            // No WAIT phase: the response word is sampled on the acceptance edge.
            rd_addr = w_req_addr;
            state_d = StResp;
            cnt_d   = '0;
            rdata_d = rsp_word(w_req_we, rd_word);
          end else begin
            state_d = StWait;
            cnt_d   = LatLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StResp;
          cnt_d   = '0;
          rdata_d = rsp_word(we_q, rd_word);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (w_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  assign w_req_ready = (state_q == StIdle);
  assign w_rsp_valid = (state_q == StResp);
  assign w_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_m_dmem_resp.sv
// Bench for m_dmem_resp: two instances (LATENCY=2 and LATENCY=1) with directed and random traffic.
// Expectations follow DMEM_BYTE_STROBE_EN when the macro is defined.
module tb_m_dmem_resp;

`ifdef DMEM_BYTE_STROBE_EN
  localparam bit StrbEn = 1'b1;
`else
  localparam bit StrbEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [11:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_strb  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];

  int checks;
  int failures;

  logic [31:0] model [int];

  m_dmem_resp #(.LATENCY(2), .AW(12)) dut0 (
    .w_clk       (clk),
    .w_rst       (rst),
    .w_req_valid (req_valid[0]),
    .w_req_ready (req_ready[0]),
    .w_req_we    (req_we[0]),
    .w_req_addr  (req_addr[0]),
    .w_req_wdata (req_wdata[0]),
    .w_req_strb  (req_strb[0]),
    .w_rsp_valid (rsp_valid[0]),
    .w_rsp_ready (rsp_ready[0]),
    .w_rsp_rdata (rsp_rdata[0])
  );

  m_dmem_resp #(.LATENCY(1), .AW(12)) dut1 (
    .w_clk       (clk),
    .w_rst       (rst),
    .w_req_valid (req_valid[1]),
    .w_req_ready (req_ready[1]),
    .w_req_we    (req_we[1]),
    .w_req_addr  (req_addr[1]),
    .w_req_wdata (req_wdata[1]),
    .w_req_strb  (req_strb[1]),
    .w_rsp_valid (rsp_valid[1]),
    .w_rsp_ready (rsp_ready[1]),
    .w_rsp_rdata (rsp_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Word after a write: bytes with strobe set (or every byte when strobes are off) take new data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (!StrbEn || strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // One complete transaction; checks latency, ready during the wait, stability under stall.
  task automatic do_txn(input int d, input logic we, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int stall,
                        output logic [31:0] rdata);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout dut%0d: ready=%b required 1", d, req_ready[d]);
    end
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_strb[d]  = strb;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      checks++;
      if (req_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL ready_busy dut%0d cycle %0d: ready=%b required 0", d, lat, req_ready[d]);
      end
    end while (rsp_valid[d] !== 1'b1 && lat < 40);
    checks++;
    if (lat != lat_of(d)) begin
      failures++;
      $display("FAIL latency dut%0d: got %0d cycles required %0d", d, lat, lat_of(d));
    end
    rdata = rsp_rdata[d];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rdata) begin
        failures++;
        $display("FAIL stall_hold dut%0d cycle %0d: valid=%b rdata=%h required 1/%h",
                 d, i, rsp_valid[d], rsp_rdata[d], rdata);
      end
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL return_idle dut%0d: valid=%b ready=%b required 0/1",
               d, rsp_valid[d], req_ready[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0) begin
        failures++;
        $display("FAIL reset_state dut%0d: valid=%b rdata=%h required 0/00000000",
                 d, rsp_valid[d], rsp_rdata[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready dut%0d: ready=%b required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] r;
    do_txn(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, r);
    checks++;
    if (r !== 32'h0) begin
      failures++;
      $display("FAIL write_rsp_zero: rdata=%h required 00000000", r);
    end
    do_txn(0, 1'b0, 12'h010, 32'h0, 4'hF, 0, r);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_deadbeef: rdata=%h required deadbeef", r);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] r;
    do_txn(1, 1'b1, 12'h044, 32'hA5A55A5A, 4'hF, 0, r);
    do_txn(1, 1'b0, 12'h044, 32'h0, 4'hF, 1, r);
    checks++;
    if (r !== 32'hA5A55A5A) begin
      failures++;
      $display("FAIL lat1_read: rdata=%h required a5a55a5a", r);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    int lat;
    do_txn(0, 1'b1, 12'h055, 32'hCAFEF00D, 4'hF, 0, r);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 12'h055; req_strb[0] = 4'hF;
    @(posedge clk);
    #1 req_addr[0] = 12'h010;  // next request, held through the stalled response
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid[0] !== 1'b1 && lat < 40);
    r = rsp_rdata[0];
    checks++;
    if (r !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL bp_read: rdata=%h required cafef00d", r);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== r || req_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall cycle %0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                 i, rsp_valid[0], rsp_rdata[0], req_ready[0], r);
      end
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_not_early: ready=%b valid=%b required 1/0", req_ready[0], rsp_valid[0]);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid[0] !== 1'b1 && lat < 40);
    checks++;
    if (lat != 2 || rsp_rdata[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bp_held_req: lat=%0d rdata=%h required 2/deadbeef", lat, rsp_rdata[0]);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
  endtask

  task automatic test_reset_priority();
    logic [31:0] r;
    do_txn(0, 1'b1, 12'h020, 32'h11111111, 4'hF, 0, r);
    @(negedge clk);
    rst = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 12'h020;
    req_wdata[0] = 32'h22222222; req_strb[0] = 4'hF;
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid[0] = 1'b0;
    do_txn(0, 1'b0, 12'h020, 32'h0, 4'hF, 0, r);
    checks++;
    if (r !== 32'h11111111) begin
      failures++;
      $display("FAIL reset_priority: rdata=%h required 11111111", r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic seen;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 12'h3FF;
    req_wdata[0] = 32'h12345678; req_strb[0] = 4'hF;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_ready: ready=%b required 1", req_ready[0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid[0] === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_rsp: rsp_valid seen=%b required 0", seen);
    end
    do_txn(0, 1'b0, 12'h3FF, 32'h0, 4'hF, 0, r);
    checks++;
    if (r !== 32'h12345678) begin
      failures++;
      $display("FAIL mid_reset_data: rdata=%h required 12345678", r);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] r;
    logic [31:0] exp;
    do_txn(0, 1'b1, 12'h030, 32'hFFFFFFFF, 4'hF, 0, r);
    do_txn(0, 1'b1, 12'h030, 32'h00000000, 4'b0101, 0, r);
    do_txn(0, 1'b0, 12'h030, 32'h0, 4'hF, 0, r);
    exp = StrbEn ? 32'hFF00FF00 : 32'h00000000;
    checks++;
    if (r !== exp) begin
      failures++;
      $display("FAIL strobe_0101: rdata=%h required %h", r, exp);
    end
    do_txn(0, 1'b1, 12'h030, 32'h12345678, 4'b0000, 0, r);
    do_txn(0, 1'b0, 12'h030, 32'h0, 4'hF, 0, r);
    exp = StrbEn ? 32'hFF00FF00 : 32'h12345678;
    checks++;
    if (r !== exp) begin
      failures++;
      $display("FAIL strobe_0000: rdata=%h required %h", r, exp);
    end
  endtask

  task automatic test_addr_bounds();
    logic [31:0] r;
    do_txn(0, 1'b1, 12'h000, 32'h0BADF00D, 4'hF, 0, r);
    do_txn(0, 1'b1, 12'hFFF, 32'h87654321, 4'hF, 0, r);
    do_txn(0, 1'b0, 12'hFFF, 32'h0, 4'hF, 0, r);
    checks++;
    if (r !== 32'h87654321) begin
      failures++;
      $display("FAIL addr_max: rdata=%h required 87654321", r);
    end
    do_txn(0, 1'b0, 12'h000, 32'h0, 4'hF, 0, r);
    checks++;
    if (r !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL addr_zero: rdata=%h required 0badf00d", r);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] exp;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [11:0] a;
    logic        we;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      a  = 12'h200 + 12'(i);
      do_txn(0, 1'b1, a, wd, 4'hF, 0, r);
      model[int'(a)] = wd;
    end
    for (int i = 0; i < 40; i++) begin
      a  = 12'h200 + 12'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      do_txn(0, we, a, wd, st, $urandom_range(0, 3), r);
      if (we) begin
        model[int'(a)] = merge(model[int'(a)], wd, st);
        exp = 32'h0;
      end else begin
        exp = model[int'(a)];
      end
      checks++;
      if (r !== exp) begin
        failures++;
        $display("FAIL random_txn %0d we=%b addr=%h: rdata=%h required %h", i, we, a, r, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_strb[d]  = '0;
      rsp_ready[d] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_latency1();
    test_backpressure();
    test_reset_priority();
    test_reset_mid();
    test_strobe();
    test_addr_bounds();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_dmem_resp.md
M_DMEM_RESP -- requirements
Module: m_dmem_resp

Interface
REQ-001 The block SHALL provide parameter LATENCY, default 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-002 The block SHALL provide parameter AW, default 12, word-address width; depth = 2**AW 32-bit words.
REQ-003 The block SHALL provide port w_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port w_rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL provide port w_req_valid  input  1  initiator presents a request.
REQ-006 The block SHALL provide port w_req_ready  output  1  responder can accept a request this cycle.
REQ-007 The block SHALL provide port w_req_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL provide port w_req_addr  input  AW  word address.
REQ-009 The block SHALL provide port w_req_wdata  input  32  write data.
REQ-010 The block SHALL provide port w_req_strb  input  4  byte write strobes; used only with DMEM_BYTE_STROBE_EN.
REQ-011 The block SHALL provide port w_rsp_valid  output  1  response available.
REQ-012 The block SHALL provide port w_rsp_ready  input  1  initiator accepts the response.
REQ-013 The block SHALL provide port w_rsp_rdata  output  32  read data; 0 for write responses.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 w_req_ready SHALL be 1 only in IDLE; it is a registered state decode, not combinational on w_req_valid.
REQ-016 A request SHALL be accepted on a rising edge where the FSM is in IDLE and w_req_valid=1; addr, we, wdata and strb are captured in that edge.
REQ-017 A write SHALL commit to storage on its acceptance edge.
REQ-018 On acceptance the FSM SHALL load the down-counter with LATENCY-1 and go to WAIT; with LATENCY=1 it SHALL go directly to RESP.
REQ-019 In WAIT the counter SHALL decrement by 1 per cycle; at count 0 the FSM SHALL go to RESP on the next edge; the counter SHALL never wrap below 0.
REQ-020 For reads, w_rsp_rdata SHALL be registered from storage on the edge entering RESP, and it SHALL reflect every write committed before that edge.
REQ-021 w_rsp_valid SHALL be 1 exactly in RESP, and rdata SHALL hold stable while w_rsp_valid=1 and w_rsp_ready=0.
REQ-022 In RESP with w_rsp_ready=1 the FSM SHALL return to IDLE on that edge, giving one accept every LATENCY+1 cycles at best (no back-to-back overlap).
REQ-023 w_req_valid asserted outside IDLE SHALL be ignored with no side effect; the initiator holds the request until ready.
REQ-024 The counter width SHALL be 4 bits; LATENCY outside 1..15 SHALL be flagged by an elaboration-time check.

Reset
REQ-025 With w_rst=1 at an edge, the FSM SHALL go to IDLE, the counter and w_rsp_rdata SHALL be 0, and w_rsp_valid SHALL be 0; w_req_ready SHALL be 1 the cycle after reset deasserts.
REQ-026 Reset SHALL take priority over acceptance: a request presented on a reset edge SHALL NOT be accepted or written.
REQ-027 Reset mid-operation (WAIT or RESP) SHALL abort the transaction with no response; a write already committed SHALL remain.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With DMEM_BYTE_STROBE_EN defined, a write SHALL update only the bytes whose w_req_strb bit is 1 (bit i -> bits 8i+7:8i), and strb=0000 SHALL be a write that changes nothing but still returns a response.
REQ-030 Without DMEM_BYTE_STROBE_EN, w_req_strb SHALL be ignored and every write SHALL update the full word.

Structure
REQ-031 A shared package dmem_pkg SHALL hold the FSM state encoding (IDLE=0, WAIT=1, RESP=2), the data-width constant 32, and the strobe width 4.
REQ-032 Storage SHALL be a sub-module m_dmem_array with one synchronous write port (with byte enables) and one read port; the FSM and counter SHALL live in m_dmem_resp.

Verification
REQ-033 The bench SHALL cover this case: reset, write addr 0x010 data 0xDEADBEEF, then read 0x010 with LATENCY=2 -> rsp_valid asserts 2 cycles after each acceptance, and read rdata is 0xDEADBEEF.
REQ-034 The bench SHALL cover this case: LATENCY=1, read accepted at cycle N -> rsp_valid=1 at cycle N+1, and ready=0 at N+1.
REQ-035 The bench SHALL cover this case: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rdata stable for all 5 cycles, and a new req_valid is not accepted until 1 cycle after rsp_ready=1.
REQ-036 The bench SHALL cover this case: w_rst pulsed during WAIT after write 0x12345678 to 0x3FF -> no response, ready=1 the cycle after reset, and a later read of 0x3FF returns 0x12345678.
REQ-037 The bench SHALL cover this case with DMEM_BYTE_STROBE_EN: write 0xFFFFFFFF, then write 0x00000000 strb=0101 -> read returns 0xFF00FF00; without the macro the same sequence reads 0x00000000.
REQ-038 The bench SHALL cover this case: write to 0xFFF (max address) then read 0x000 -> 0xFFF holds its data, and 0x000 is unaffected (no address wrap aliasing).
